// File: rtl/regbus_master.sv
// Register-bus initiator: turns single/burst read and write commands into
// auto-incrementing single-cycle register-bus strobes, streaming write data
// in and registered read data out over valid/ready handshakes.
module regbus_master #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              bus_cs,
    output logic              bus_wren,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ISS  = 3'd2,
        RD_WAIT = 3'd3,
        RD_OUT  = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic              bus_cs_q, bus_cs_d;
    logic              bus_wren_q, bus_wren_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_last_q, rd_last_d;

    logic [ADDR_W-1:0] addr_inc;
    logic [LEN_W-1:0]  beat_inc;

    // Address wraps modulo 2^ADDR_W; the beat counter only matters up to len_q.
    assign addr_inc = addr_q + 1'b1;
    assign beat_inc = beat_q + 1'b1;

    // Next-state, strobe generation and read-beat capture.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        bus_cs_d    = 1'b0;
        bus_wren_d  = 1'b0;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rd_valid_d  = rd_valid_q;
        rd_data_d   = rd_data_q;
        rd_last_d   = rd_last_q;
        cmd_ready   = 1'b0;
        wr_ready    = 1'b0;
        done        = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    len_d  = cmd_len;
                    beat_d = '0;
                    if (cmd_write) begin
                        state_d = WR;
                    end else begin
                        // First read strobe goes out on the accepting edge.
                        state_d    = RD_ISS;
                        bus_cs_d   = 1'b1;
                        bus_addr_d = cmd_addr;
                    end
                end
            end
            WR: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    bus_cs_d    = 1'b1;
                    bus_wren_d  = 1'b1;
                    bus_addr_d  = addr_q;
                    bus_wdata_d = wr_data;
                    addr_d      = addr_inc;
                    beat_d      = beat_inc;
                    // Final strobe is on the bus during the DONE cycle.
                    if (beat_q == len_q) begin
                        state_d = DONE;
                    end
                end
            end
            RD_ISS: begin
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // Responder data is registered: valid one cycle after the strobe.
                rd_data_d  = bus_rdata;
                rd_valid_d = 1'b1;
                rd_last_d  = (beat_q == len_q);
                state_d    = RD_OUT;
            end
            RD_OUT: begin
                if (rd_ready) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    if (rd_last_q) begin
                        state_d = DONE;
                    end else begin
                        addr_d     = addr_inc;
                        beat_d     = beat_inc;
                        state_d    = RD_ISS;
                        bus_cs_d   = 1'b1;
                        bus_addr_d = addr_inc;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            bus_cs_q    <= 1'b0;
            bus_wren_q  <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            bus_cs_q    <= bus_cs_d;
            bus_wren_q  <= bus_wren_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            rd_last_q   <= rd_last_d;
        end
    end

    assign bus_cs    = bus_cs_q;
    assign bus_wren  = bus_wren_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_last   = rd_last_q;

endmodule

// File: tb/tb_regbus_master.sv
// Testbench for regbus_master: a register-file responder, a memory-level
// reference model and a scoreboard monitor that checks bus strobes and read
// beats against expectations queued when each command is issued.
module tb_regbus_master;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int LW = 5;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_exp_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } rd_exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          done;
    logic          bus_cs;
    logic          bus_wren;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_wr_cyc = 0;
    int first_wr_cyc = 0;
    int wr_strobes = 0;
    int last_rd_hs_cyc = 0;
    int rd_mode = 0;   // 0 random, 1 always ready, 2 hold off
    bit mem_clr = 1'b1;

    wr_exp_t       exp_wr[$];
    logic [AW-1:0] exp_ra[$];
    rd_exp_t       exp_rd[$];
    logic [DW-1:0] wdata_list[$];
    logic [DW-1:0] model_mem [32];
    logic [DW-1:0] resp_mem [32];

    regbus_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .done(done),
        .bus_cs(bus_cs), .bus_wren(bus_wren), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Register-file responder with registered read data.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) resp_mem[i] <= '0;
            bus_rdata <= '0;
        end else if (bus_cs) begin
            if (bus_wren) resp_mem[bus_addr] <= bus_wdata;
            else          bus_rdata <= resp_mem[bus_addr];
        end
    end

    // Read consumer ready pattern.
    always @(posedge clk) begin
        #1;
        case (rd_mode)
            1:       rd_ready = 1'b1;
            2:       rd_ready = 1'b0;
            default: rd_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    logic          wr_hs_prev = 1'b0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] hold_data = '0;
    logic          hold_last = 1'b0;
    always @(negedge clk) begin
        wr_exp_t       we;
        rd_exp_t       re;
        logic [AW-1:0] ra;
        cyc++;
        if (!rst) begin
            chk("wren_without_cs", 64'(bus_wren & ~bus_cs), 64'd0);
            chk("strobe_while_rd_valid", 64'(rd_valid & bus_cs), 64'd0);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("cmd_ready_in_done", 64'(cmd_ready), 64'd0);
            end
            if (hold_prev) begin
                chk("rd_valid_held", 64'(rd_valid), 64'd1);
                chk("rd_data_held", 64'(rd_data), 64'(hold_data));
                chk("rd_last_held", 64'(rd_last), 64'(hold_last));
            end
        end
        if (wr_hs_prev || (bus_cs && bus_wren))
            chk("wr_strobe_after_hs", 64'(bus_cs && bus_wren), 64'(wr_hs_prev));
        if (bus_cs && bus_wren) begin
            if (wr_strobes == 0) first_wr_cyc = cyc;
            wr_strobes++;
            last_wr_cyc = cyc;
            if (exp_wr.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write_strobe actual addr=%0d required none", bus_addr);
            end else begin
                we = exp_wr.pop_front();
                chk("wr_bus_addr", 64'(bus_addr), 64'(we.a));
                chk("wr_bus_wdata", 64'(bus_wdata), 64'(we.d));
            end
        end
        if (bus_cs && !bus_wren) begin
            if (exp_ra.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_read_strobe actual addr=%0d required none", bus_addr);
            end else begin
                ra = exp_ra.pop_front();
                chk("rd_bus_addr", 64'(bus_addr), 64'(ra));
            end
        end
        if (rd_valid && rd_ready && !rst) begin
            last_rd_hs_cyc = cyc;
            if (exp_rd.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_read_beat actual data=%0h required none", rd_data);
            end else begin
                re = exp_rd.pop_front();
                chk("rd_data", 64'(rd_data), 64'(re.d));
                chk("rd_last", 64'(rd_last), 64'(re.last));
            end
        end
        wr_hs_prev = wr_valid && wr_ready;
        hold_prev  = rd_valid && !rd_ready && !rst;
        hold_data  = rd_data;
        hold_last  = rd_last;
    end

    // Queue the expected bus/read traffic and update the memory model.
    task automatic prep_cmd(input bit w, input logic [AW-1:0] a, input int len);
        logic [AW-1:0] ai;
        logic [DW-1:0] d;
        for (int i = 0; i <= len; i++) begin
            ai = a + AW'(i);
            if (w) begin
                d = (wdata_list.size() != 0) ? wdata_list.pop_front() : $urandom;
                exp_wr.push_back('{a: ai, d: d});
                model_mem[ai] = d;
            end else begin
                exp_ra.push_back(ai);
                exp_rd.push_back('{d: model_mem[ai], last: (i == len)});
            end
        end
    endtask

    // Present a command; called and returns just after a rising edge.
    task automatic issue_cmd(input bit w, input logic [AW-1:0] a, input int len);
        int t = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = LW'(len);
        @(negedge clk);
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout actual cmd_ready=0 required 1");
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        if (w) chk("wr_state_entry", 64'(wr_ready), 64'd1);
        else   chk("rd_first_strobe", 64'(bus_cs && !bus_wren), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic feed(input int n, input bit gaps);
        int g;
        int t;
        for (int i = 0; i < n; i++) begin
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            if (g != 0) begin
                wr_valid = 1'b0;
                repeat (g) begin @(posedge clk); #1; end
            end
            wr_valid = 1'b1;
            wr_data  = exp_wr[exp_wr.size() - (n - i)].d;
            t = 0;
            @(negedge clk);
            while (!wr_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!wr_ready) begin
                checks++; errors++;
                $display("FAIL wr_ready_timeout actual 0 required 1");
            end
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
    endtask

    task automatic finish_cmd(input int d0, input bit w);
        int t = 0;
        while (done_cnt == d0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0) begin
            checks++; errors++;
            $display("FAIL done_timeout actual no done required done");
        end
        repeat (3) @(negedge clk);
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("exp_wr_empty", 64'(exp_wr.size()), 64'd0);
        chk("exp_rd_empty", 64'(exp_rd.size() + exp_ra.size()), 64'd0);
        if (w) chk("done_with_last_strobe", 64'(done_cyc), 64'(last_wr_cyc));
        else   chk("done_after_last_beat", 64'(done_cyc), 64'(last_rd_hs_cyc + 1));
        @(posedge clk); #1;
    endtask

    task automatic run_cmd(input bit w, input logic [AW-1:0] a, input int len, input bit gaps);
        int d0;
        d0 = done_cnt;
        prep_cmd(w, a, len);
        issue_cmd(w, a, len);
        if (w) feed(len + 1, gaps);
        finish_cmd(d0, w);
    endtask

    initial begin
        int d0;
        logic [DW-1:0] sd;
        logic [AW-1:0] ra;
        int rl;
        bit rw;
        for (int i = 0; i < 32; i++) model_mem[i] = '0;
        rd_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_clr = 1'b0;
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_bus_cs", 64'(bus_cs), 64'd0);
        chk("rst_bus_wren", 64'(bus_wren), 64'd0);
        chk("rst_bus_addr", 64'(bus_addr), 64'd0);
        chk("rst_bus_wdata", 64'(bus_wdata), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(posedge clk); #1;

        // Single write then read back.
        wdata_list.push_back(32'hDEADBEEF);
        run_cmd(1'b1, 5'd3, 0, 1'b0);
        run_cmd(1'b0, 5'd3, 0, 1'b0);

        // Continuous burst write, then read across it.
        wdata_list = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        wr_strobes = 0;
        run_cmd(1'b1, 5'd2, 3, 1'b0);
        chk("burst_strobe_count", 64'(wr_strobes), 64'd4);
        chk("burst_back_to_back", 64'(last_wr_cyc - first_wr_cyc), 64'd3);
        rd_mode = 0;
        run_cmd(1'b0, 5'd0, 5, 1'b0);

        // Backpressure on the first read beat.
        d0 = done_cnt;
        rd_mode = 2;
        prep_cmd(1'b0, 5'd2, 1);
        issue_cmd(1'b0, 5'd2, 1);
        rl = 0;
        @(negedge clk);
        while (!rd_valid && rl < 20) begin
            @(negedge clk);
            rl++;
        end
        chk("bp_rd_valid", 64'(rd_valid), 64'd1);
        sd = rd_data;
        chk("bp_first_data", 64'(sd), 64'h0A0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_stable", 64'(rd_valid), 64'd1);
            chk("bp_data_stable", 64'(rd_data), 64'(sd));
            chk("bp_no_strobe", 64'(bus_cs), 64'd0);
        end
        rd_mode = 1;
        finish_cmd(d0, 1'b0);

        // Address wrap.
        wdata_list = '{32'h11, 32'h22};
        run_cmd(1'b1, 5'd31, 1, 1'b0);
        run_cmd(1'b0, 5'd0, 0, 1'b0);
        chk("wrap_model_addr0", 64'(model_mem[0]), 64'h22);

        // Reset in the middle of a write burst.
        d0 = done_cnt;
        prep_cmd(1'b1, 5'd8, 1);
        issue_cmd(1'b1, 5'd8, 7);
        feed(2, 1'b0);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("mid_rst_bus_cs", 64'(bus_cs), 64'd0);
        chk("mid_rst_bus_wren", 64'(bus_wren), 64'd0);
        chk("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("mid_rst_bus_addr", 64'(bus_addr), 64'd0);
        chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("mid_rst_strobes", 64'(exp_wr.size()), 64'd0);
        @(posedge clk); #1;
        run_cmd(1'b0, 5'd8, 2, 1'b0);

        // Randomized commands.
        for (int n = 0; n < 24; n++) begin
            rw = 1'($urandom_range(0, 1));
            ra = AW'($urandom_range(0, 31));
            rl = int'($urandom_range(0, 7));
            rd_mode = int'($urandom_range(0, 1));
            run_cmd(rw, ra, rl, 1'($urandom_range(0, 1)));
        end
        rd_mode = 1;
        run_cmd(1'b0, 5'd28, 7, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regbus_master.md
Name: regbus_master

Overview:
Initiator for the single-cycle register bus (cs / wren / reg_addr / write data / registered read data) served by the register-file responders. Accepts single or burst read/write commands on a valid/ready command port. Issues auto-incrementing bus accesses, streams write data in and read data out with valid/ready handshakes, and pulses done at the end of each command. Sits between a host-side command source (CPU bridge, UART/debug port) and one register-file responder.

Parameters:
ADDR_W, 5, bus address width; matches responder reg_addr.
DATA_W, 32, bus data width.
LEN_W, 5, burst length field width; beats = cmd_len+1, so 1 to 2^LEN_W beats.

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_W  start address
cmd_len  in  LEN_W  beats minus one
wr_valid  in  1  write beat available
wr_ready  out  1  high only in WR state
wr_data  in  DATA_W  write beat data
rd_valid  out  1  read beat available
rd_ready  in  1  consumer accepts read beat
rd_data  out  DATA_W  read beat data
rd_last  out  1  qualifies final read beat
done  out  1  one-cycle pulse, command complete
bus_cs  out  1  to responder cs
bus_wren  out  1  to responder wren
bus_addr  out  ADDR_W  to responder reg_addr
bus_wdata  out  DATA_W  to responder data_in
bus_rdata  in  DATA_W  from responder data_out (registered; valid the cycle after a read strobe)

Behaviour:
- Clock is clk; reset is synchronous and active-high (rst). Both fixed.
- Reset: state=IDLE; bus_cs, bus_wren, bus_addr, bus_wdata, rd_valid, rd_data, rd_last, done all 0. Reset mid-command abandons the burst with no done pulse and no further strobes.
- All bus_* outputs are registered. bus_wren=1 only when bus_cs=1. When not strobing, bus_cs=0 and bus_wren=0; bus_addr and bus_wdata hold their last values.
- Internal cur_addr (ADDR_W) and beat counter (LEN_W). cur_addr increments modulo 2^ADDR_W after each beat (31 -> 0); no error on wrap.
- States: IDLE, WR, RD_ISS, RD_WAIT, RD_OUT, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch addr, len and write; clear the beat count. Go to WR if write, else to RD_ISS. The RD_ISS strobe is registered on this same edge.
- WR: wr_ready=1. Each wr_valid&wr_ready drives one strobe on the next cycle: bus_cs=1, bus_wren=1, bus_addr=cur_addr, bus_wdata=wr_data.
  - Gaps in wr_valid produce gaps in bus_cs.
  - Peak rate is one beat per cycle.
  - On the handshake of beat cmd_len, go to DONE. The last strobe coincides with the DONE cycle.
- RD_ISS (1 cycle): bus_cs=1, bus_wren=0, bus_addr=cur_addr. Go to RD_WAIT.
- RD_WAIT (1 cycle): bus_cs=0. Capture bus_rdata into rd_data; set rd_valid=1 and rd_last=(beat==cmd_len). Go to RD_OUT.
- RD_OUT: rd_valid, rd_data and rd_last are held stable until rd_ready.
  - On handshake: rd_valid=0 next cycle.
  - If last beat, go to DONE.
  - Otherwise increment addr and beat, and re-enter RD_ISS with the strobe registered on that edge.
  - Minimum 3 cycles per read beat; no new read strobe while a beat is unaccepted.
- DONE (1 cycle): done=1, then go to IDLE. cmd_ready=0 in DONE.
- Ignored inputs: cmd_valid outside IDLE; wr_valid outside WR (wr_ready=0); rd_ready while rd_valid=0.
- Command-to-first-strobe latency:
  - Read: 1 cycle after cmd handshake.
  - Write: 1 cycle after the first wr handshake. WR is entered the cycle after cmd handshake.

Test Plan:
- Reset: hold rst=1 for 2 cycles mid-activity -> after release cmd_ready=1; bus_cs=0, bus_wren=0, rd_valid=0, done=0, bus_addr=0.
- Single write: cmd write, addr=3, len=0; wr_data=0xDEADBEEF -> exactly one cycle with bus_cs=1, bus_wren=1, bus_addr=3, bus_wdata=0xDEADBEEF, the cycle after wr handshake, with done=1 that same cycle. Then read addr=3, len=0 -> rd_data=0xDEADBEEF, rd_last=1.
- Burst: write addr=2, len=3, data 0xA0..0xA3 with wr_valid continuous -> 4 consecutive strobes at addr 2,3,4,5. Then read addr=0, len=5 from a freshly reset responder -> beats 0,0,0xA0,0xA1,0xA2,0xA3, rd_last only on the 6th, one done.
- Backpressure: read len=1 with rd_ready=0 for 5 cycles on beat 0 -> rd_data/rd_valid stable, no bus_cs until handshake; then beat 1 issued.
- Wrap: write addr=31, len=1, data 0x11, 0x22 -> strobes at bus_addr 31 then 0; readback of addr 0 = 0x22.
- Reset mid-burst: write len=7, assert rst after 2 beats -> IDLE next cycle, no done, no further strobes; a new read command is accepted immediately after release.
